// File: rtl/dac_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the DAC write arbiter slice.
// MCP4911 frame length and the 10 kHz load spacing at CLOCK_50 live here.
package dac_write_arbiter_pkg;

  localparam int DAC_DW               = 10;
  localparam int DAC_NREQ             = 4;
  localparam int MCP4911_FRAME_CYCLES = 40;
  localparam int DAC_MIN_GAP          = 5000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dac_write_if.sv
// Requester/DAC-side bundle of the arbiter: sample requests in, load strobe and data out.
interface dac_write_if #(
  parameter int NREQ = 4,
  parameter int DW   = 10
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      dac_data;
  logic               dac_load;
  logic               busy;
  logic [2:0]         grant_id;

  // Sample sources drive requests and watch their acks.
  modport master (
    output req, req_data,
    input  ack, dac_data, dac_load, busy, grant_id
  );

  // The arbiter consumes requests and drives the spi2dac/pwm side.
  modport slave (
    input  req, req_data,
    output ack, dac_data, dac_load, busy, grant_id
  );

endinterface

// File: rtl/dac_write_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req searching from rr_ptr upward, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      rr_ptr,
  output logic            valid,
  output logic [2:0]      idx
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!valid && req[j] && (j == (int'(rr_ptr) + i) % NREQ)) begin
          valid = 1'b1;
          idx   = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter sharing the spi2dac/pwm sample path among NREQ sources.
// One sample per frame; the bus stays busy until both the serial frame and the minimum gap expire.
module dac_write_arbiter
  import dac_write_arbiter_pkg::*;
#(
  parameter int NREQ        = DAC_NREQ,
  parameter int DW          = DAC_DW,
  parameter int XFER_CYCLES = MCP4911_FRAME_CYCLES,
  parameter int MIN_GAP     = DAC_MIN_GAP
) (
  input logic        CLOCK_50,
  input logic        rst_n,
  dac_write_if.slave bus
);

  localparam int CNT_MAX = max_int(MIN_GAP, XFER_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  // The load cycle counts as 1, so the gap is over once the count reaches MIN_GAP-1 in GAP;
  // the following IDLE cycle then makes the load-to-load distance exactly MIN_GAP.
  localparam logic [CW-1:0] XFER_LIM = CW'(XFER_CYCLES);
  localparam logic [CW-1:0] GAP_LIM  = CW'((MIN_GAP > 1) ? MIN_GAP - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
  localparam logic [2:0]    LAST_IDX = 3'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [2:0]      rr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   dac_data_q;
  logic            dac_load_q;
  logic            busy_q;
  logic [2:0]      grant_id_q;

  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic [DW-1:0]   pick_data;
  logic [NREQ-1:0] pick_onehot;
  logic            start_xfer;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Constant-indexed mux keeps the sample select and the ack decode free of variable slices.
  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_data      = bus.req_data[i*DW +: DW];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  assign start_xfer = (state_q == ST_IDLE) && pick_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_valid)        state_d = ST_LOAD;
      ST_LOAD:                        state_d = ST_XFER;
      ST_XFER: if (cnt_q >= XFER_LIM) state_d = ST_GAP;
      ST_GAP:  if (cnt_q >= GAP_LIM)  state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      dac_data_q <= '0;
      dac_load_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= '0;
      dac_load_q <= 1'b0;
      if (start_xfer) begin
        ack_q      <= pick_onehot;
        dac_data_q <= pick_data;
        dac_load_q <= 1'b1;
        grant_id_q <= pick_idx;
        rr_ptr_q   <= (pick_idx == LAST_IDX) ? 3'd0 : pick_idx + 3'd1;
        busy_q     <= 1'b1;
        cnt_q      <= CW'(1);
      end else begin
        // Saturating count: a long-stalled frame can never wrap and re-trigger a compare.
        if (state_q != ST_IDLE && cnt_q != CNT_SAT) cnt_q <= cnt_q + CW'(1);
        if (state_q == ST_GAP && state_d == ST_IDLE) busy_q <= 1'b0;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.dac_data = dac_data_q;
  assign bus.dac_load = dac_load_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Scoreboarded bench: a production-spaced instance (MIN_GAP=5000) and a fast one (MIN_GAP=2).
// Stimulus threads push expected grants; per-instance monitors pop and compare on every dac_load.
module tb_dac_write_arbiter;
  import dac_write_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 10;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            gap;   // required cycles since previous load, 0 = not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst_n_slow;
  logic rst_n_fast;

  always #5 clk = ~clk;

  dac_write_if #(.NREQ(NREQ), .DW(DW)) bs ();
  dac_write_if #(.NREQ(NREQ), .DW(DW)) bf ();

  dac_write_arbiter #(.NREQ(NREQ), .DW(DW), .XFER_CYCLES(40), .MIN_GAP(5000)) u_slow (
    .CLOCK_50 (clk),
    .rst_n    (rst_n_slow),
    .bus      (bs.slave)
  );

  dac_write_arbiter #(.NREQ(NREQ), .DW(DW), .XFER_CYCLES(40), .MIN_GAP(2)) u_fast (
    .CLOCK_50 (clk),
    .rst_n    (rst_n_fast),
    .bus      (bf.slave)
  );

  exp_t exp_slow[$];
  exp_t exp_fast[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- monitors ----------------
  int   cyc_s = 0, last_s = 0, cyc_f = 0, last_f = 0;
  exp_t es, ef;

  always @(negedge clk) begin
    cyc_s++;
    if (bs.dac_load) begin
      check("slow_load_expected", 32'(exp_slow.size() != 0), 1);
      if (exp_slow.size() != 0) begin
        es = exp_slow.pop_front();
        check("slow_ack",      bs.ack,      onehot(es.id));
        check("slow_grant_id", bs.grant_id, es.id);
        check("slow_dac_data", bs.dac_data, es.data);
        check("slow_busy",     bs.busy,     1);
        if (es.gap != 0) check("slow_load_spacing", cyc_s - last_s, es.gap);
      end
      last_s = cyc_s;
    end else if (bs.ack != '0) begin
      check("slow_stray_ack", bs.ack, 0);
    end
  end

  always @(negedge clk) begin
    cyc_f++;
    if (bf.dac_load) begin
      check("fast_load_expected", 32'(exp_fast.size() != 0), 1);
      if (exp_fast.size() != 0) begin
        ef = exp_fast.pop_front();
        check("fast_ack",      bf.ack,      onehot(ef.id));
        check("fast_grant_id", bf.grant_id, ef.id);
        check("fast_dac_data", bf.dac_data, ef.data);
        check("fast_busy",     bf.busy,     1);
        if (ef.gap != 0) check("fast_load_spacing", cyc_f - last_f, ef.gap);
      end
      last_f = cyc_f;
    end else if (bf.ack != '0) begin
      check("fast_stray_ack", bf.ack, 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_fast_load(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bf.dac_load) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic wait_fast_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bf.busy) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 1);
  endtask

  // ---------------- stimulus ----------------
  task automatic run_slow();
    int n;
    bit done;
    // Release was on a negedge; count rising edges until the first load shows up.
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bs.dac_load) begin
        n = i;
        break;
      end
    end
    check("slow_first_load_within_2_edges", 32'(n >= 1 && n <= 2), 1);
    done = 1'b0;
    for (int i = 0; i < 21000; i++) begin
      if (exp_slow.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("slow_rr_sequence_done", 32'(done), 1);
    bs.req = '0;
  endtask

  task automatic run_fast();
    int n;
    repeat (3) @(negedge clk);

    // Single requester: one-cycle latency from req to load/ack.
    bf.req_data[2*DW +: DW] = 10'h2A5;
    exp_fast.push_back('{2, 10'h2A5, 0});
    bf.req = 4'b0100;
    @(negedge clk);
    check("fast_single_load_latency", bf.dac_load, 1);
    check("fast_single_ack_latency",  bf.ack,      4'b0100);
    bf.req = '0;
    wait_fast_idle("fast_single_idle_timeout");

    // Starvation: req[3] steady, req[0] re-raised right after each of its acks -> alternation.
    bf.req_data[0*DW +: DW] = 10'h011;
    bf.req_data[3*DW +: DW] = 10'h3C3;
    exp_fast.push_back('{3, 10'h3C3, 0});
    exp_fast.push_back('{0, 10'h011, 42});
    exp_fast.push_back('{3, 10'h3C3, 42});
    exp_fast.push_back('{0, 10'h012, 42});
    bf.req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_fast_load("fast_starve_load_timeout", 100);
      if (bf.ack[0] && k < 3) begin
        bf.req[0] = 1'b0;
        @(negedge clk);
        bf.req_data[0*DW +: DW] = 10'h012;
        bf.req[0] = 1'b1;
      end
    end
    bf.req = '0;
    wait_fast_idle("fast_starve_idle_timeout");

    // Mid-frame request: req[1] rising during XFER waits for the next IDLE.
    bf.req_data[0*DW +: DW] = 10'h0AA;
    bf.req_data[1*DW +: DW] = 10'h155;
    exp_fast.push_back('{0, 10'h0AA, 0});
    exp_fast.push_back('{1, 10'h155, 42});
    bf.req = 4'b0001;
    wait_fast_load("fast_midframe_first_timeout", 10);
    bf.req = '0;
    repeat (11) @(negedge clk);
    bf.req[1] = 1'b1;
    check("fast_midframe_busy", bf.busy, 1);
    check("fast_midframe_no_ack", bf.ack, 0);
    wait_fast_load("fast_midframe_second_timeout", 60);
    bf.req = '0;
    wait_fast_idle("fast_midframe_idle_timeout");

    // Reset mid-frame at cnt=20, then resume with req[3].
    bf.req_data[2*DW +: DW] = 10'h101;
    exp_fast.push_back('{2, 10'h101, 0});
    bf.req = 4'b0100;
    wait_fast_load("fast_prereset_load_timeout", 10);
    bf.req = '0;
    repeat (19) @(negedge clk);
    rst_n_fast = 1'b0;
    #1;
    check("fast_reset_busy",     bf.busy,     0);
    check("fast_reset_load",     bf.dac_load, 0);
    check("fast_reset_ack",      bf.ack,      0);
    check("fast_reset_dac_data", bf.dac_data, 0);
    check("fast_reset_grant_id", bf.grant_id, 0);
    bf.req_data[3*DW +: DW] = 10'h3FF;
    bf.req = 4'b1000;
    exp_fast.push_back('{3, 10'h3FF, 0});
    repeat (3) @(negedge clk);
    rst_n_fast = 1'b1;
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bf.dac_load) begin
        n = i;
        break;
      end
    end
    check("fast_resume_load_within_2_edges", 32'(n >= 1 && n <= 2), 1);
    bf.req = '0;
    wait_fast_idle("fast_resume_idle_timeout");

    // No requests: stay idle and hold the last sample.
    repeat (60) @(negedge clk);
    check("fast_hold_dac_data", bf.dac_data, 10'h3FF);
    check("fast_hold_grant_id", bf.grant_id, 3);
    check("fast_hold_busy",     bf.busy,     0);
  endtask

  initial begin
    rst_n_slow  = 1'b0;
    rst_n_fast  = 1'b0;
    bs.req      = 4'b1111;
    bs.req_data = {10'h2AA, 10'h30F, 10'h0F0, 10'h001};
    bf.req      = '0;
    bf.req_data = '0;
    repeat (3) @(negedge clk);
    check("slow_reset_ack",      bs.ack,      0);
    check("slow_reset_load",     bs.dac_load, 0);
    check("slow_reset_dac_data", bs.dac_data, 0);
    check("slow_reset_busy",     bs.busy,     0);
    check("fast_reset0_grant_id", bf.grant_id, 0);

    exp_slow.push_back('{0, 10'h001, 0});
    exp_slow.push_back('{1, 10'h0F0, 5000});
    exp_slow.push_back('{2, 10'h30F, 5000});
    exp_slow.push_back('{3, 10'h2AA, 5000});
    exp_slow.push_back('{0, 10'h001, 5000});
    rst_n_slow = 1'b1;
    rst_n_fast = 1'b1;

    fork
      run_slow();
      run_fast();
    join

    repeat (5) @(negedge clk);
    check("slow_queue_drained", exp_slow.size(), 0);
    check("fast_queue_drained", exp_fast.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
